tick_divider: RTL and testbench

- Parametrised synchronous successor to the 19-bit ripple divider on the 50 MHz system clock.
- Produces a programmable-rate one-cycle tick and a 50% square wave for the sequencer and tempo logic.
- The divisor is run-time loadable. A new divisor takes effect only at the next period boundary, so a tempo change never produces a short or long glitch period.
- Adds enable, synchronous clear and a pending-load flag; the ripple divider has none of these.

---
 rtl/tick_divider.sv | 99 +++++++++
 tb/tb_tick_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tick_divider
//  Brief    : Programmable-rate tick and 50% square-wave generator with a
//             run-time loadable divisor that changes only at period
//             boundaries, plus enable, synchronous clear and a pending flag.
//  Revision : 1.0  initial release
// ============================================================================
module tick_divider #(
    parameter int WIDTH       = 19,
    parameter int DEFAULT_DIV = 500000
) (
    input  logic             CLK_50_MHz,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             square,
    output logic [WIDTH-1:0] div_active,
    output logic             div_pending
);

    localparam logic [WIDTH-1:0] c_DEFAULT = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_square;
    logic [WIDTH-1:0] r_div_active;
    logic [WIDTH-1:0] r_div_pend_val;
    logic             r_div_pending;

    logic [WIDTH-1:0] w_div_clamped;
    logic             w_last;
    logic             w_wrap;

    // A zero divisor is meaningless, so it is stored as one (tick every cycle).
    assign w_div_clamped = (div_value == '0) ? c_ONE : div_value;

    // The period wraps on the last phase of the active divisor while counting.
    assign w_last = (r_count == (r_div_active - c_ONE));
    assign w_wrap = enable & w_last;

    // Counter, tick, square and divisor bookkeeping; new divisors only land at count 0.
    always_ff @(posedge CLK_50_MHz or posedge reset) begin
        if (reset) begin
            r_count        <= '0;
            r_tick         <= 1'b0;
            r_square       <= 1'b0;
            r_div_active   <= c_DEFAULT;
            r_div_pend_val <= c_DEFAULT;
            r_div_pending  <= 1'b0;
        end else if (sync_clr) begin
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_square <= 1'b0;
            if (div_load) begin
                r_div_active  <= w_div_clamped;
                r_div_pending <= 1'b0;
            end else if (r_div_pending) begin
                r_div_active  <= r_div_pend_val;
                r_div_pending <= 1'b0;
            end
        end else if (w_wrap) begin
            r_count  <= '0;
            r_tick   <= 1'b1;
            r_square <= ~r_square;
            // A load coinciding with the wrap supersedes any older pending value.
            if (div_load) begin
                r_div_active  <= w_div_clamped;
                r_div_pending <= 1'b0;
            end else if (r_div_pending) begin
                r_div_active  <= r_div_pend_val;
                r_div_pending <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            if (enable) begin
                r_count <= r_count + c_ONE;
            end
            // Last load before the wrap wins.
            if (div_load) begin
                r_div_pend_val <= w_div_clamped;
                r_div_pending  <= 1'b1;
            end
        end
    end

    assign count       = r_count;
    assign tick        = r_tick;
    assign square      = r_square;
    assign div_active  = r_div_active;
    assign div_pending = r_div_pending;

endmodule
`default_nettype wire

// File: tb/tb_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_divider
//  Brief    : Scoreboard bench for tick_divider (WIDTH=8, DEFAULT_DIV=10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_divider;

    localparam int W    = 8;
    localparam int DDIV = 10;

    typedef struct {
        int cnt;
        int tck;
        int sq;
        int act;
        int pend;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         sync_clr = 1'b0;
    logic [W-1:0] div_value = '0;
    logic         div_load = 1'b0;
    logic [W-1:0] count;
    logic         tick;
    logic         square;
    logic [W-1:0] div_active;
    logic         div_pending;

    tick_divider #(.WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
        .CLK_50_MHz (clk),
        .reset      (reset),
        .enable     (enable),
        .sync_clr   (sync_clr),
        .div_value  (div_value),
        .div_load   (div_load),
        .count      (count),
        .tick       (tick),
        .square     (square),
        .div_active (div_active),
        .div_pending(div_pending)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model: phase within the period, divisor in use, queued divisor.
    int m_phase = 0, m_tick = 0, m_sq = 0, m_div = DDIV, m_next = DDIV, m_has_next = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_tick = 0; m_sq = 0;
        m_div = DDIV; m_next = DDIV; m_has_next = 0;
    endtask

    // Advance the model by one clock edge given the inputs present at that edge.
    task automatic model_step(input int en, input int clr, input int val, input int ld);
        int n;
        n = (val == 0) ? 1 : val;
        if (clr) begin
            m_phase = 0; m_tick = 0; m_sq = 0;
            if (ld) m_div = n; else if (m_has_next) m_div = m_next;
            if (ld || m_has_next) m_has_next = 0;
        end else if (en && ((m_phase + 1) % m_div == 0)) begin
            m_phase = 0; m_tick = 1; m_sq = 1 - m_sq;
            if (ld) m_div = n; else if (m_has_next) m_div = m_next;
            m_has_next = 0;
        end else begin
            m_tick = 0;
            if (en) m_phase = m_phase + 1;
            if (ld) begin m_next = n; m_has_next = 1; end
        end
    endtask

    // Apply one cycle of stimulus, update the model and queue the expectation.
    task automatic drive(input int rst, input int en, input int clr, input int val, input int ld);
        exp_t e;
        @(negedge clk);
        reset     = rst[0];
        enable    = en[0];
        sync_clr  = clr[0];
        div_value = W'(val);
        div_load  = ld[0];
        if (rst) begin
            model_reset();
            #1;
            chk("async_rst_count", int'(count), 0);
            chk("async_rst_tick", int'(tick), 0);
            chk("async_rst_square", int'(square), 0);
            chk("async_rst_active", int'(div_active), DDIV);
            chk("async_rst_pending", int'(div_pending), 0);
        end else begin
            model_step(en, clr, val, ld);
        end
        e.cnt = m_phase; e.tck = m_tick; e.sq = m_sq; e.act = m_div; e.pend = m_has_next;
        q.push_back(e);
    endtask

    // Monitor: every output is registered, so each edge presents a result to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("tick", int'(tick), e.tck);
                chk("square", int'(square), e.sq);
                chk("div_active", int'(div_active), e.act);
                chk("div_pending", int'(div_pending), e.pend);
            end
        end
    end

    initial begin
        int en, clr, ld, val, r;
        // Reset held over a couple of edges, then free-run with the default divisor.
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 2 * DDIV + 3; i++) drive(0, 1, 0, 0, 0);

        // Load 3 mid-period from a divisor of 5, then observe the new spacing.
        drive(0, 0, 1, 5, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 3, 1);
        for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 0);

        // Zero divisor becomes 1: continuous tick, then hold while disabled.
        drive(0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // Load exactly on the wrap edge, and two loads before a wrap.
        drive(0, 0, 1, 4, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 7, 1);
        for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 6, 1);
        drive(0, 1, 0, 9, 1);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);

        // sync_clr at count 3 with a pending divisor of 4.
        drive(0, 0, 1, 8, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 4, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);

        // Randomised traffic, biased toward small divisors so wraps are frequent.
        for (int i = 0; i < 4000; i++) begin
            en  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
            ld  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            r   = $urandom_range(0, 9);
            val = (r < 7) ? $urandom_range(0, 8) : (r < 9) ? $urandom_range(0, 20) : $urandom_range(0, 255);
            drive(0, en, clr, val, ld);
        end

        // Async reset mid-period: count=2, square=1, pending set.
        drive(0, 0, 1, 5, 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 9, 1);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 0);

        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
